// File: rtl/memshare_rqst_sched.sv
// Read-request sequencer for the SCU.memShare() period: one start pulse becomes a
// counted valid/ready burst. Optional DRC0 rebase is built only with MEMSHARE_RQST_SCHED_DRC_REBASE_EN.
module memshare_rqst_sched #(
  parameter int ADDR_WIDTH    = 7,
  parameter int OPERAND_WIDTH = 3,
  parameter int RQST_NUM      = 8,
  parameter int CNT_WIDTH     = $clog2(RQST_NUM + 1)
) (
  input  logic                     sys_clk,
  input  logic                     rstn,
  input  logic                     scu_begin_i,
  input  logic [ADDR_WIDTH-1:0]    base_addr_i,
  input  logic [OPERAND_WIDTH-1:0] stride_i,
  input  logic                     drc_valid_i,
  input  logic [1:0]               drc_result_i,
  input  logic [ADDR_WIDTH-1:0]    drc_base_addr_i,
  input  logic                     rqst_ready_i,
  output logic                     rqst_valid_o,
  output logic [ADDR_WIDTH-1:0]    rqst_addr_o,
  output logic [OPERAND_WIDTH-1:0] increment_operand_o,
  output logic                     scu_busy_o,
  output logic                     scu_done_o,
  output logic                     err_overrun_o,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Handshake: a request transfers on any cycle where rqst_valid_o and rqst_ready_i
  // are both high; valid and address are held unchanged until that happens.
  state_t                   r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]     r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]    r_addr, w_addr_nxt;
  logic [OPERAND_WIDTH-1:0] r_incr, w_incr_nxt;
  logic                     r_valid, w_valid_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_done, w_done_nxt;
  logic                     r_err, w_err_nxt;
  logic                     w_hs;

  assign w_hs = r_valid & rqst_ready_i;

`ifndef MEMSHARE_RQST_SCHED_DRC_REBASE_EN
  logic w_unused_rebase;
  assign w_unused_rebase = ^{drc_result_i[0], drc_base_addr_i};
`endif

  always_ff @(posedge sys_clk or posedge rstn) begin
    if (rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_incr  <= OPERAND_WIDTH'(1);
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_incr  <= w_incr_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_incr_nxt  = r_incr;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (scu_begin_i) begin
          w_state_nxt = S_ISSUE;
          w_addr_nxt  = base_addr_i;
          w_cnt_nxt   = CNT_WIDTH'(RQST_NUM);
          w_valid_nxt = 1'b1;
        end
      end
      S_ISSUE: begin
        if (scu_begin_i) w_err_nxt = 1'b1;
        if (w_hs) begin
          w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
`ifdef MEMSHARE_RQST_SCHED_DRC_REBASE_EN
          if (drc_valid_i & drc_result_i[0]) begin
            w_addr_nxt = drc_base_addr_i;
          end else
`endif
          if (drc_valid_i & drc_result_i[1]) begin
            w_addr_nxt = r_addr + ADDR_WIDTH'(stride_i);
            w_incr_nxt = stride_i;
          end else begin
            w_addr_nxt = r_addr + ADDR_WIDTH'(1);
            w_incr_nxt = OPERAND_WIDTH'(1);
          end
          // Last transfer: drop valid on this same edge and flag completion next cycle.
          if (r_cnt == CNT_WIDTH'(1)) begin
            w_state_nxt = S_DONE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (scu_begin_i) w_err_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_ISSUE);
  end

  assign rqst_valid_o        = r_valid;
  assign rqst_addr_o         = r_addr;
  assign increment_operand_o = r_incr;
  assign scu_busy_o          = r_busy;
  assign scu_done_o          = r_done;
  assign err_overrun_o       = r_err;
  assign dbg_state_o         = r_state;

endmodule

// File: tb/tb_memshare_rqst_sched.sv
// Directed bench for memshare_rqst_sched: expected addresses are queued when a burst
// is started and popped by a monitor on every observed handshake.
module tb_memshare_rqst_sched;

  logic       sys_clk = 1'b0;
  logic       rstn;
  logic       scu_begin_i;
  logic [6:0] base_addr_i;
  logic [2:0] stride_i;
  logic       drc_valid_i;
  logic [1:0] drc_result_i;
  logic [6:0] drc_base_addr_i;
  logic       rqst_ready_i;
  logic       rqst_valid_o;
  logic [6:0] rqst_addr_o;
  logic [2:0] increment_operand_o;
  logic       scu_busy_o;
  logic       scu_done_o;
  logic       err_overrun_o;
  logic [1:0] dbg_state_o;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];

  memshare_rqst_sched dut (
    .sys_clk             (sys_clk),
    .rstn                (rstn),
    .scu_begin_i         (scu_begin_i),
    .base_addr_i         (base_addr_i),
    .stride_i            (stride_i),
    .drc_valid_i         (drc_valid_i),
    .drc_result_i        (drc_result_i),
    .drc_base_addr_i     (drc_base_addr_i),
    .rqst_ready_i        (rqst_ready_i),
    .rqst_valid_o        (rqst_valid_o),
    .rqst_addr_o         (rqst_addr_o),
    .increment_operand_o (increment_operand_o),
    .scu_busy_o          (scu_busy_o),
    .scu_done_o          (scu_done_o),
    .err_overrun_o       (err_overrun_o),
    .dbg_state_o         (dbg_state_o)
  );

  // clock / watchdog
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // scoreboard monitor: every handshake must match the head of the expected queue
  always @(negedge sys_clk) begin
    if (!rstn && rqst_valid_o && rqst_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_handshake", {25'd0, rqst_addr_o}, 32'hffff_ffff);
      end else begin
        check("hs_addr", {25'd0, rqst_addr_o}, {25'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_seq(input logic [6:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(7'(base + 7'(i)));
  endtask

  task automatic start(input logic [6:0] base);
    base_addr_i = base;
    scu_begin_i = 1'b1;
    tick();
    scu_begin_i = 1'b0;
    check("start_valid", {31'd0, rqst_valid_o}, 32'd1);
    check("start_addr", {25'd0, rqst_addr_o}, {25'd0, base});
    check("start_busy", {31'd0, scu_busy_o}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int n);
    int seen;
    seen = -1;
    for (int i = 1; i <= n + 6; i++) begin
      tick();
      if (scu_done_o) begin
        seen = i;
        break;
      end
    end
    check(tag, seen, n);
    check({tag, "_valid"}, {31'd0, rqst_valid_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, scu_busy_o}, 32'd0);
  endtask

  initial begin
    logic [6:0] a;
    logic       rdy;
    rstn            = 1'b1;
    scu_begin_i     = 1'b0;
    base_addr_i     = '0;
    stride_i        = '0;
    drc_valid_i     = 1'b0;
    drc_result_i    = '0;
    drc_base_addr_i = '0;
    rqst_ready_i    = 1'b1;
    tick();
    tick();
    check("rst_valid", {31'd0, rqst_valid_o}, 32'd0);
    check("rst_addr", {25'd0, rqst_addr_o}, 32'd0);
    check("rst_incr", {29'd0, increment_operand_o}, 32'd1);
    check("rst_busy", {31'd0, scu_busy_o}, 32'd0);
    check("rst_done", {31'd0, scu_done_o}, 32'd0);
    check("rst_err", {31'd0, err_overrun_o}, 32'd0);
    check("rst_state", {30'd0, dbg_state_o}, 32'd0);
    rstn = 1'b0;
    tick();

    // plain burst
    push_seq(7'h10, 8);
    start(7'h10);
    wait_done("done_t1", 8);
    tick();
    check("done_one_cycle", {31'd0, scu_done_o}, 32'd0);
    check("q_empty_t1", exp_q.size(), 0);

    // wrap-around
    push_seq(7'h7e, 8);
    start(7'h7e);
    tick();
    check("wrap_addr1", {25'd0, rqst_addr_o}, 32'h7f);
    tick();
    check("wrap_addr2", {25'd0, rqst_addr_o}, 32'h00);
    wait_done("done_t2", 6);
    tick();

    // DRC1 stride on handshakes 2 and 3
    exp_q.push_back(7'h20); exp_q.push_back(7'h21); exp_q.push_back(7'h24);
    exp_q.push_back(7'h27);
    push_seq(7'h28, 4);
    start(7'h20);
    tick();
    check("s_addr2", {25'd0, rqst_addr_o}, 32'h21);
    check("s_incr1", {29'd0, increment_operand_o}, 32'd1);
    drc_valid_i = 1'b1; drc_result_i = 2'b10; stride_i = 3'd3;
    tick();
    check("s_addr3", {25'd0, rqst_addr_o}, 32'h24);
    check("s_incr2", {29'd0, increment_operand_o}, 32'd3);
    tick();
    check("s_addr4", {25'd0, rqst_addr_o}, 32'h27);
    check("s_incr3", {29'd0, increment_operand_o}, 32'd3);
    drc_valid_i = 1'b0; drc_result_i = 2'b00;
    tick();
    check("s_addr5", {25'd0, rqst_addr_o}, 32'h28);
    check("s_incr4", {29'd0, increment_operand_o}, 32'd1);
    wait_done("done_t3", 4);
    tick();

    // ready pattern 1,0,0,1; DRC1 offered only on stalled cycles must be ignored
    push_seq(7'h30, 8);
    start(7'h30);
    for (int c = 0; c < 16; c++) begin
      rdy          = (c % 4 == 0) || (c % 4 == 3);
      rqst_ready_i = rdy;
      drc_valid_i  = !rdy;
      drc_result_i = 2'b10;
      stride_i     = 3'd5;
      a            = rqst_addr_o;
      tick();
      if (!rdy) begin
        check("hold_addr", {25'd0, rqst_addr_o}, {25'd0, a});
        check("hold_valid", {31'd0, rqst_valid_o}, 32'd1);
      end
    end
    check("done_t4", {31'd0, scu_done_o}, 32'd1);
    rqst_ready_i = 1'b1; drc_valid_i = 1'b0; drc_result_i = 2'b00;
    tick();
    check("q_empty_t4", exp_q.size(), 0);

    // overrun during ISSUE
    push_seq(7'h50, 8);
    start(7'h50);
    tick();
    scu_begin_i = 1'b1; base_addr_i = 7'h00;
    tick();
    scu_begin_i = 1'b0;
    check("ovr_err", {31'd0, err_overrun_o}, 32'd1);
    check("ovr_addr", {25'd0, rqst_addr_o}, 32'h52);
    wait_done("done_t5", 6);
    check("ovr_err_sticky", {31'd0, err_overrun_o}, 32'd1);
    tick();

    // reset at 4th request of a second burst
    push_seq(7'h60, 3);
    start(7'h60);
    tick(); tick(); tick();
    check("pre_rst_addr", {25'd0, rqst_addr_o}, 32'h63);
    rstn = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, rqst_valid_o}, 32'd0);
    check("mid_rst_addr", {25'd0, rqst_addr_o}, 32'd0);
    check("mid_rst_incr", {29'd0, increment_operand_o}, 32'd1);
    check("mid_rst_busy", {31'd0, scu_busy_o}, 32'd0);
    check("mid_rst_err", {31'd0, err_overrun_o}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state_o}, 32'd0);
    check("q_empty_rst", exp_q.size(), 0);
    tick();
    rstn = 1'b0;
    tick();

    // overrun in DONE, then back-to-back restart at the earliest legal cycle
    push_seq(7'h00, 8);
    start(7'h00);
    wait_done("done_t6", 8);
    scu_begin_i = 1'b1; base_addr_i = 7'h70;
    tick();
    scu_begin_i = 1'b0;
    check("done_ovr_err", {31'd0, err_overrun_o}, 32'd1);
    check("done_ovr_valid", {31'd0, rqst_valid_o}, 32'd0);
    check("done_ovr_state", {30'd0, dbg_state_o}, 32'd0);
    push_seq(7'h08, 8);
    start(7'h08);
    wait_done("done_t7", 8);
    tick();

    // DRC0 + DRC1 together on the first handshake
    exp_q.push_back(7'h10);
`ifdef MEMSHARE_RQST_SCHED_DRC_REBASE_EN
    push_seq(7'h40, 7);
`else
    push_seq(7'h12, 7);
`endif
    start(7'h10);
    drc_valid_i = 1'b1; drc_result_i = 2'b11; drc_base_addr_i = 7'h40; stride_i = 3'd2;
    tick();
    drc_valid_i = 1'b0; drc_result_i = 2'b00;
`ifdef MEMSHARE_RQST_SCHED_DRC_REBASE_EN
    check("rebase_addr", {25'd0, rqst_addr_o}, 32'h40);
    check("rebase_incr", {29'd0, increment_operand_o}, 32'd1);
`else
    check("norebase_addr", {25'd0, rqst_addr_o}, 32'h12);
    check("norebase_incr", {29'd0, increment_operand_o}, 32'd2);
`endif
    wait_done("done_t8", 7);
    tick();
    check("q_empty_final", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memshare_rqst_sched.md
# memshare_rqst_sched

Sequencer for the message-passing buffer read port during the SCU.memShare() period. It turns one `scu_begin_i` pulse into a counted burst of valid/ready read requests. The request address steps by 1 by default, or by the shared-memory stride operand when the DRC1 result is asserted. It sits between the SCU control FSM and the message-passing buffer read port, upstream of the operand-tracking pipeline.

## Interface
Parameters:
- `ADDR_WIDTH`, default 7: message-passing buffer address width.
- `OPERAND_WIDTH`, default 3: stride operand width.
- `RQST_NUM`, default 8: read requests issued per SCU.memShare() period (≥1).
- `CNT_WIDTH`, default `$clog2(RQST_NUM+1)`: width of the remaining-request counter.

Ports:
- `sys_clk` input 1: single clock, rising edge.
- `rstn` input 1: reset, **asynchronous, active-high**. The port name is kept for codebase consistency; its polarity is high.
- `scu_begin_i` input 1: single-cycle start pulse.
- `base_addr_i` input `ADDR_WIDTH`: first read address, sampled with `scu_begin_i`.
- `stride_i` input `OPERAND_WIDTH`: increment operand, sampled on each accepted request.
- `drc_valid_i` input 1: the `drc_result_i` value is valid this cycle.
- `drc_result_i` input 2: DRC flags. Bit 1 = DRC1 (use stride). Bit 0 = DRC0 (rebase; only used when the macro is defined).
- `drc_base_addr_i` input `ADDR_WIDTH`: rebase target address.
- `rqst_ready_i` input 1: the buffer accepts a request this cycle.
- `rqst_valid_o` output 1: read request valid.
- `rqst_addr_o` output `ADDR_WIDTH`: read request address.
- `increment_operand_o` output `OPERAND_WIDTH`: step applied at the last handshake.
- `scu_busy_o` output 1: high while in ISSUE.
- `scu_done_o` output 1: one-cycle pulse after the final handshake.
- `err_overrun_o` output 1: sticky flag, set by `scu_begin_i` arriving while not IDLE.

## Operation
- FSM has three states: IDLE, ISSUE, DONE. Reset state is IDLE.
- IDLE:
  - On `scu_begin_i`: load `rqst_addr_o` ← `base_addr_i` and counter ← `RQST_NUM`, then go to ISSUE.
- ISSUE:
  - `rqst_valid_o`=1. Address and valid stay stable until `rqst_ready_i`.
  - A handshake is `rqst_valid_o & rqst_ready_i`. On each handshake, the counter decrements and the next address is chosen by this priority:
    1. If `drc_valid_i & drc_result_i[0]` and the macro is defined: address ← `drc_base_addr_i`.
    2. Else if `drc_valid_i & drc_result_i[1]`: address ← address + zero-extended `stride_i`, and `increment_operand_o` ← `stride_i`.
    3. Else: address ← address + 1, and `increment_operand_o` ← 1.
  - The handshake that brings the counter from 1 to 0 moves the FSM to DONE. On that handshake `rqst_valid_o` drops in the same clock edge.
- DONE:
  - `scu_done_o`=1 for exactly one cycle, then the FSM returns to IDLE.
  - A `scu_begin_i` in DONE is an overrun. It is ignored and sets the error flag.
- Arithmetic: address addition is modulo 2^`ADDR_WIDTH`, so it wraps silently (127+1 → 0 at the default width).
- `stride_i`=0 is legal: the address repeats.
- DRC inputs outside a handshake cycle are ignored.
- `scu_begin_i` while in ISSUE or DONE: ignored, and `err_overrun_o` ← 1. Only reset clears `err_overrun_o`.
- Reset asserted mid-burst: immediate return to IDLE with every output at its reset value. No partial state survives.

## Timing
- All outputs are registered.
- Reset values:
  - `rqst_valid_o`=0, `rqst_addr_o`=0.
  - `increment_operand_o`=1.
  - `scu_busy_o`=0, `scu_done_o`=0, `err_overrun_o`=0.
- Start latency:
  - `scu_begin_i` high in cycle N → `rqst_valid_o`=1 and `rqst_addr_o`=`base_addr_i` in cycle N+1.
- Per-handshake timing:
  - A handshake in cycle M → the new address is visible in cycle M+1.
  - With `rqst_ready_i` held high, one request is issued per cycle.
- Burst timing, with `rqst_ready_i` held high:
  - The final handshake falls in cycle N+`RQST_NUM`.
  - `scu_done_o` is high in cycle N+`RQST_NUM`+1.
  - A new `scu_begin_i` is accepted from cycle N+`RQST_NUM`+2.
- Zero-cycle combinational paths from inputs to outputs: none.

## Configuration
- Macro: `MEMSHARE_RQST_SCHED_DRC_REBASE_EN`.
- Defined: DRC0 rebase is active with top priority over DRC1. On a rebase, `increment_operand_o` is left unchanged.
- Undefined: `drc_result_i[0]` and `drc_base_addr_i` are unused, and rebase logic is not synthesised.

## Test plan
- Reset, then start with `RQST_NUM`=8, base=0x10, ready always high, no DRC:
  - Addresses 0x10–0x17 on consecutive cycles.
  - `scu_done_o` one cycle after the 8th handshake.
- Base=0x7E, no DRC:
  - Addresses 0x7E, 0x7F, 0x00, 0x01, … (wrap-around).
- Base=0x20, DRC1 valid on handshakes 2 and 3 with `stride_i`=3:
  - Addresses 0x20, 0x21, 0x24, 0x27, 0x28.
  - `increment_operand_o`=3 after handshakes 2 and 3, then 1 after handshake 4.
- Ready toggled 1,0,0,1:
  - Address held stable and `rqst_valid_o` held high while ready is low.
  - The count completes only after 8 handshakes.
- `scu_begin_i` pulsed during ISSUE, and reset asserted at the 4th request of a second burst:
  - Burst unaffected; `err_overrun_o`=1.
  - On reset, all outputs return to their reset values immediately, with `err_overrun_o`=0.
- Macro defined, DRC0 and DRC1 asserted together at handshake 1, `drc_base_addr_i`=0x40:
  - Next address is 0x40 (rebase wins over stride).
  - With the macro undefined, the next address is base+`stride_i`.
